mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among NR_REQ requesters.
// One transaction in flight: accept (IDLE), present to memory (ISSUE), route response (WAIT).
module mem_port_arbiter #(
  parameter int NR_REQ   = 2,
  parameter int ADDR_LEN = 64,
  parameter int DATA_LEN = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NR_REQ-1:0]              req_valid,
  output logic [NR_REQ-1:0]              req_ready,
  input  logic [NR_REQ*ADDR_LEN-1:0]     req_addr,
  input  logic [NR_REQ-1:0]              req_wen,
  input  logic [NR_REQ*DATA_LEN-1:0]     req_wdata,
  input  logic [NR_REQ*DATA_LEN/8-1:0]   req_wmask,
  output logic [NR_REQ-1:0]              rsp_valid,
  input  logic [NR_REQ-1:0]              rsp_ready,
  output logic [DATA_LEN-1:0]            rsp_rdata,
  output logic                           mem_valid,
  input  logic                           mem_ready,
  output logic [ADDR_LEN-1:0]            mem_addr,
  output logic                           mem_wen,
  output logic [DATA_LEN-1:0]            mem_wdata,
  output logic [DATA_LEN/8-1:0]          mem_wmask,
  input  logic                           mem_rsp_valid,
  output logic                           mem_rsp_ready,
  input  logic [DATA_LEN-1:0]            mem_rsp_rdata
);

  localparam int MASK_LEN = DATA_LEN / 8;
  localparam int IDX_W    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_last_grant;
  logic [ADDR_LEN-1:0] r_addr;
  logic                r_wen;
  logic [DATA_LEN-1:0] r_wdata;
  logic [MASK_LEN-1:0] r_wmask;
  logic                r_mem_valid;

  logic [IDX_W-1:0]    w_cand;
  logic [IDX_W-1:0]    w_winner;
  logic                w_found;
  logic [NR_REQ-1:0]   w_win_oh;
  logic [NR_REQ-1:0]   w_grant_oh;
  logic                w_in_wait;

  // Upward search starting just past the previous grant.
  always_comb begin
    w_cand   = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= NR_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last_grant) + i) % NR_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_win_oh   = '0;
    w_grant_oh = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      w_win_oh[k]   = (w_winner == IDX_W'(k));
      w_grant_oh[k] = (r_grant == IDX_W'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NR_REQ - 1);
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_mem_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_winner;
            r_addr      <= req_addr[int'(w_winner)*ADDR_LEN +: ADDR_LEN];
            r_wen       <= req_wen[w_winner];
            r_wdata     <= req_wdata[int'(w_winner)*DATA_LEN +: DATA_LEN];
            r_wmask     <= req_wmask[int'(w_winner)*MASK_LEN +: MASK_LEN];
            r_mem_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Writes also complete here; the response doubles as the write ack.
          if (mem_rsp_valid && rsp_ready[r_grant]) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_wait = (r_state == S_WAIT);

  // Gate on i_rst so nothing looks accepted while reset is held.
  assign req_ready     = (r_state == S_IDLE && w_found && !i_rst) ? w_win_oh : '0;
  assign mem_valid     = r_mem_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign rsp_valid     = (w_in_wait && mem_rsp_valid) ? w_grant_oh : '0;
  assign mem_rsp_ready = w_in_wait && rsp_ready[r_grant];
  assign rsp_rdata     = w_in_wait ? mem_rsp_rdata : '0;

endmodule
